// File: rtl/multicycle_control.sv
// multicycle_control: main sequencing FSM for the multi-cycle MIPS32 core.
// Drives every datapath mux select and write-enable from the current state,
// stalls on MemReady, traps on unsupported encodings and counts retirements.
module multicycle_control (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [5:0]  Opcode,
    input  logic [5:0]  Funct,
    input  logic        Zero,
    input  logic        MemReady,
    output logic        PCWrite,
    output logic        PCWriteCond,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        MemtoReg,
    output logic        IRWrite,
    output logic        ALUSrcA,
    output logic        RegWrite,
    output logic        RegDst,
    output logic [1:0]  PCSource,
    output logic [1:0]  ALUOp,
    output logic [1:0]  ALUSrcB,
    output logic        PCWriteEn,
    output logic [3:0]  State,
    output logic        Retire,
    output logic        Illegal,
    output logic [31:0] InstrCount
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,  S_FETCH  = 4'd1,  S_DECODE = 4'd2,  S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,  S_MEMWB  = 4'd5,  S_MEMWR  = 4'd6,  S_EXEC   = 4'd7,
        S_RWB    = 4'd8,  S_BRANCH = 4'd9,  S_ADDIEX = 4'd10, S_ADDIWB = 4'd11,
        S_JUMP   = 4'd12, S_TRAP   = 4'd13
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] instr_count_q, instr_count_d;
    logic        funct_ok;

    // R-type functions the ALU actually implements
    always_comb begin
        funct_ok = 1'b0;
        case (Funct)
            6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: funct_ok = 1'b1;
            default: funct_ok = 1'b0;
        endcase
    end

    // Next-state sequencing; unused encodings fall back to IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  if (MemReady) state_d = S_DECODE;
            S_DECODE: begin
                case (Opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = funct_ok ? S_EXEC : S_TRAP;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_TRAP;
                endcase
            end
            // IR is stable here, so Opcode still distinguishes lw from sw
            S_MEMADR: state_d = (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (MemReady) state_d = S_MEMWB;
            S_MEMWR:  if (MemReady) state_d = S_FETCH;
            S_EXEC:   state_d = S_RWB;
            S_ADDIEX: state_d = S_ADDIWB;
            S_MEMWB, S_RWB, S_BRANCH, S_ADDIWB, S_JUMP: state_d = S_FETCH;
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_IDLE;
        endcase
    end

    // Control decode from the current state; MemReady gates the memory-side
    // writes so a stalled cycle never updates IR or PC and never retires
    always_comb begin
        PCWrite = 1'b0; PCWriteCond = 1'b0; IorD = 1'b0; MemRead = 1'b0;
        MemWrite = 1'b0; MemtoReg = 1'b0; IRWrite = 1'b0; ALUSrcA = 1'b0;
        RegWrite = 1'b0; RegDst = 1'b0; PCSource = 2'b00; ALUOp = 2'b00;
        ALUSrcB = 2'b00; Retire = 1'b0; Illegal = 1'b0;
        case (state_q)
            S_FETCH:  begin MemRead = 1'b1; ALUSrcB = 2'b01; IRWrite = MemReady; PCWrite = MemReady; end
            S_DECODE: ALUSrcB = 2'b11;
            S_MEMADR: begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; end
            S_MEMRD:  begin MemRead = 1'b1; IorD = 1'b1; end
            S_MEMWB:  begin RegWrite = 1'b1; MemtoReg = 1'b1; Retire = 1'b1; end
            S_MEMWR:  begin MemWrite = 1'b1; IorD = 1'b1; Retire = MemReady; end
            S_EXEC:   begin ALUSrcA = 1'b1; ALUOp = 2'b10; end
            S_RWB:    begin RegWrite = 1'b1; RegDst = 1'b1; Retire = 1'b1; end
            S_BRANCH: begin ALUSrcA = 1'b1; ALUOp = 2'b01; PCWriteCond = 1'b1; PCSource = 2'b01; Retire = 1'b1; end
            S_ADDIEX: begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; end
            S_ADDIWB: begin RegWrite = 1'b1; Retire = 1'b1; end
            S_JUMP:   begin PCWrite = 1'b1; PCSource = 2'b10; Retire = 1'b1; end
            S_TRAP:   Illegal = 1'b1;
            default:  ;
        endcase
    end

    assign PCWriteEn  = PCWrite | (PCWriteCond & Zero);
    assign State      = state_q;
    assign InstrCount = instr_count_q;

    // Retirement counter wraps naturally at 32 bits
    always_comb instr_count_d = instr_count_q + {31'd0, Retire};

    // State and counter registers
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q       <= S_IDLE;
            instr_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            instr_count_q <= instr_count_d;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: instruction-level reference model builds a per-cycle
// expectation schedule; a driver replays it onto the inputs and pushes each
// cycle's expectation into a scoreboard that a negedge monitor checks.
module tb_multicycle_control;

    localparam logic [3:0] ST_IDLE = 4'd0,  ST_FETCH = 4'd1,  ST_DECODE = 4'd2,
                           ST_MEMADR = 4'd3, ST_MEMRD = 4'd4, ST_MEMWB = 4'd5,
                           ST_MEMWR = 4'd6, ST_EXEC = 4'd7,   ST_RWB = 4'd8,
                           ST_BRANCH = 4'd9, ST_ADDIEX = 4'd10, ST_ADDIWB = 4'd11,
                           ST_JUMP = 4'd12, ST_TRAP = 4'd13;

    logic        Clk, Reset_n, Zero, MemReady;
    logic [5:0]  Opcode, Funct;
    logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
    logic        ALUSrcA, RegWrite, RegDst, PCWriteEn, Retire, Illegal;
    logic [1:0]  PCSource, ALUOp, ALUSrcB;
    logic [3:0]  State;
    logic [31:0] InstrCount;

    multicycle_control dut (
        .Clk(Clk), .Reset_n(Reset_n), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
        .MemReady(MemReady), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
        .IRWrite(IRWrite), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite), .RegDst(RegDst),
        .PCSource(PCSource), .ALUOp(ALUOp), .ALUSrcB(ALUSrcB), .PCWriteEn(PCWriteEn),
        .State(State), .Retire(Retire), .Illegal(Illegal), .InstrCount(InstrCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [3:0]  st;
        logic        mr;
        logic        z;
        logic        ret;
        logic        rw;
        logic        mw;
        logic        m2r;
        logic        pcwe;
        logic [1:0]  psrc;
        logic        ill;
        logic [31:0] cnt;
    } rec_t;

    rec_t        sched[$];
    rec_t        exp_q[$];
    logic [31:0] mcnt;
    logic [5:0]  cur_op, cur_fn;
    int          n_chk = 0;
    int          n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // Append one expected cycle; the count seen is the pre-retire count
    task automatic add(input logic [3:0] st, input logic mr, input logic z,
                       input logic ret, input logic rw, input logic mw,
                       input logic m2r, input logic pcwe, input logic [1:0] psrc,
                       input logic ill);
        rec_t r;
        r.op = cur_op; r.fn = cur_fn; r.st = st; r.mr = mr; r.z = z;
        r.ret = ret; r.rw = rw; r.mw = mw; r.m2r = m2r; r.pcwe = pcwe;
        r.psrc = psrc; r.ill = ill; r.cnt = mcnt;
        if (ret) mcnt = mcnt + 32'd1;
        sched.push_back(r);
    endtask

    task automatic plain(input logic [3:0] st);
        add(st, rb(), rb(), 0, 0, 0, 0, 0, 2'b00, 0);
    endtask

    // Instruction-level model: expands one instruction into its cycles.
    // nf/nm = MemReady-low cycles in the fetch / data-memory phase.
    task automatic gen(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input int nf, input int nm);
        cur_op = op; cur_fn = fn;
        repeat (nf) add(ST_FETCH, 0, rb(), 0, 0, 0, 0, 0, 2'b00, 0);
        add(ST_FETCH, 1, rb(), 0, 0, 0, 0, 1, 2'b00, 0);
        plain(ST_DECODE);
        case (op)
            6'b100011: begin
                plain(ST_MEMADR);
                repeat (nm) add(ST_MEMRD, 0, rb(), 0, 0, 0, 0, 0, 2'b00, 0);
                add(ST_MEMRD, 1, rb(), 0, 0, 0, 0, 0, 2'b00, 0);
                add(ST_MEMWB, rb(), rb(), 1, 1, 0, 1, 0, 2'b00, 0);
            end
            6'b101011: begin
                plain(ST_MEMADR);
                repeat (nm) add(ST_MEMWR, 0, rb(), 0, 0, 1, 0, 0, 2'b00, 0);
                add(ST_MEMWR, 1, rb(), 1, 0, 1, 0, 0, 2'b00, 0);
            end
            6'b000000: begin
                if (fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010}) begin
                    plain(ST_EXEC);
                    add(ST_RWB, rb(), rb(), 1, 1, 0, 0, 0, 2'b00, 0);
                end else begin
                    repeat (20) add(ST_TRAP, rb(), rb(), 0, 0, 0, 0, 0, 2'b00, 1);
                end
            end
            6'b000100: add(ST_BRANCH, rb(), z, 1, 0, 0, 0, z, 2'b01, 0);
            6'b001000: begin
                plain(ST_ADDIEX);
                add(ST_ADDIWB, rb(), rb(), 1, 1, 0, 0, 0, 2'b00, 0);
            end
            6'b000010: add(ST_JUMP, rb(), rb(), 1, 0, 0, 0, 1, 2'b10, 0);
            default: repeat (20) add(ST_TRAP, rb(), rb(), 0, 0, 0, 0, 0, 2'b00, 1);
        endcase
    endtask

    // Drive up to n scheduled cycles (n < 0: all)
    task automatic run(input int n);
        int k = 0;
        while (sched.size() != 0 && (n < 0 || k < n)) begin
            rec_t r;
            r = sched.pop_front();
            @(posedge Clk); #1;
            MemReady = r.mr; Zero = r.z; Opcode = r.op; Funct = r.fn;
            exp_q.push_back(r);
            k++;
        end
    endtask

    task automatic release_reset(input logic preload_max);
        @(posedge Clk); #1;
        Reset_n = 1'b1;
        mcnt = 32'd0;
        if (preload_max) begin
            force dut.instr_count_q = 32'hFFFF_FFFF;
            #1;
            release dut.instr_count_q;
            mcnt = 32'hFFFF_FFFF;
        end
        cur_op = Opcode; cur_fn = Funct;
        add(ST_IDLE, MemReady, Zero, 0, 0, 0, 0, 0, 2'b00, 0);
        exp_q.push_back(sched.pop_back());
    endtask

    task automatic do_reset(input logic preload_max);
        @(posedge Clk); #1;
        Reset_n = 1'b0;
        repeat (2) @(posedge Clk);
        release_reset(preload_max);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_state"}, 32'(State), 32'd0);
        chk({nm, "_count"}, InstrCount, 32'd0);
        chk({nm, "_outs"}, 32'({PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
                                IRWrite, ALUSrcA, RegWrite, RegDst, PCSource, ALUOp,
                                ALUSrcB, PCWriteEn, Retire, Illegal}), 32'd0);
    endtask

    // Scoreboard monitor: compare every presented cycle against its expectation
    always @(negedge Clk) begin
        rec_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("state", 32'(State), 32'(e.st));
            chk("retire", 32'(Retire), 32'(e.ret));
            chk("regwrite", 32'(RegWrite), 32'(e.rw));
            chk("memwrite", 32'(MemWrite), 32'(e.mw));
            chk("memtoreg", 32'(MemtoReg), 32'(e.m2r));
            chk("pcwriteen", 32'(PCWriteEn), 32'(e.pcwe));
            chk("pcsource", 32'(PCSource), 32'(e.psrc));
            chk("illegal", 32'(Illegal), 32'(e.ill));
            chk("instrcount", InstrCount, e.cnt);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [5:0] ops [6];
        logic [5:0] fns [5];
        ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        Reset_n = 1'b0; Zero = 1'b0; MemReady = 1'b0; Opcode = '0; Funct = '0;
        mcnt = '0; cur_op = '0; cur_fn = '0;
        #3;
        chk_all_zero("reset");
        release_reset(1'b0);

        // directed: lw, sw with 3-cycle stall, beq taken then not taken
        gen(6'b100011, 6'd0, 0, 0, 0);
        gen(6'b101011, 6'd0, 0, 0, 3);
        gen(6'b000100, 6'd0, 1, 0, 0);
        gen(6'b000100, 6'd0, 0, 0, 0);
        run(-1);

        // random legal instruction mix with random stalls
        for (int i = 0; i < 40; i++) begin
            gen(ops[$urandom_range(0, 5)], fns[$urandom_range(0, 4)], rb(),
                $urandom_range(0, 3), $urandom_range(0, 3));
        end
        run(-1);

        // reset asserted while lw is stalled in MEMRD
        gen(6'b100011, 6'd0, 0, 0, 5);
        run(5);
        sched.delete();
        @(posedge Clk); #1;
        chk("pre_reset_state", 32'(State), 32'(ST_MEMRD));
        Reset_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        release_reset(1'b0);

        // unsupported R-type funct, then unsupported opcode
        gen(6'b000010, 6'd0, 0, 0, 0);
        gen(6'b000000, 6'b000111, 0, 1, 0);
        run(-1);
        do_reset(1'b0);
        gen(6'b111111, 6'd0, 0, 0, 0);
        run(-1);

        // counter wrap: preload all-ones, retire one jump, observe zero
        do_reset(1'b1);
        gen(6'b000010, 6'd0, 0, 0, 0);
        gen(6'b001000, 6'd0, 0, 0, 0);
        run(-1);

        @(posedge Clk); #1;
        @(negedge Clk); #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
